regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of `register_file` between NREQ writeback sources, e.g. ALU result and load data.
- Arbitration is round-robin with per-source valid/ready handshakes.
- Drives registered `rd`/`datawb`/`regwren` into `register_file`.
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW/WAW hazards against in-flight writes.

Parameters:
- DWIDTH, 32, data width of writeback values; matches `register_file`.
- NREQ, 2, number of writeback requesters (2..4).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- req_valid_i  input  NREQ  requester n has a write pending
- req_rd_i  input  NREQ*5  destination register per requester
- req_data_i  input  NREQ*DWIDTH  writeback data per requester
- req_ready_o  output  NREQ  one-hot grant; transfer when valid and ready both high
- rd_o  output  5  to `register_file` `rd_i`
- datawb_o  output  DWIDTH  to `register_file` `datawb_i`
- regwren_o  output  1  to `register_file` `regwren_i`
- issue_i  input  1  decode issues an instruction that will write `issue_rd_i`
- issue_rd_i  input  5  destination of the issued instruction
- rs1_i  input  5  source 1 of the instruction in decode
- rs2_i  input  5  source 2 of the instruction in decode
- stall_o  output  1  hazard: decode must hold
- pending_o  output  32  scoreboard bitmap

Behaviour:
- Reset (rst low, asynchronous): regwren_o=0, rd_o=0, datawb_o=0, pending=0, rr pointer=NREQ-1, so requester 0 wins first. req_ready_o and stall_o then follow combinationally from the reset state.
- Arbitration, combinational in the same cycle:
  - Search starts at index (ptr+1) mod NREQ and picks the first valid requester.
  - req_ready_o is one-hot on that requester, zero if none are valid.
  - req_ready_o never asserts for a non-valid requester.
- Pointer update: on a clock edge with a grant, ptr becomes the granted index; with no grant, ptr holds.
- Output register, 1-cycle latency: on the edge after a grant, rd_o/datawb_o take the granted rd/data.
  - regwren_o=1 if granted rd!=0, else 0. An x0 write is accepted and silently dropped.
  - With no grant, regwren_o=0 and rd_o/datawb_o hold their previous values.
- No backpressure from `register_file`; the arbiter accepts at most one write per cycle.
- Scoreboard:
  - Set: issue_i && issue_rd_i!=0 sets pending[issue_rd_i] at the edge.
  - Clear: regwren_o==1 clears pending[rd_o] at the edge. This is the same edge on which `register_file` commits the write.
  - Same register set and cleared on one edge: set wins.
  - pending[0] is constant 0.
- Hazard, combinational:
  - stall_o = pending[rs1_i] | pending[rs2_i] | (issue_i & pending[issue_rd_i]).
  - The last term blocks WAW; decode must not assert issue_i for a pending rd. If it does anyway, the bit stays 1 (no counting).
- Requester misuse: if a requester drops valid before ready, the arbiter is unaffected and the request is simply not seen.
- Mid-operation reset: an in-flight output write is discarded (regwren_o=0 immediately); the scoreboard is cleared.

Optional Feature:
- WBARB_FWD_EN defined: adds outputs fwd1_valid_o, fwd1_data_o, fwd2_valid_o, fwd2_data_o (DWIDTH).
  - fwdN_valid_o = regwren_o && rd_o==rsN_i; fwdN_data_o = datawb_o.
  - The pending terms for rs1/rs2 are removed from stall_o when the matching fwd is valid, saving one stall cycle.
- Macro undefined: ports absent; stall_o exactly as in Behaviour.

Decomposition:
- Package regfile_pkg:
  - NUM_REGS=32, REG_AW=5, typedef reg_addr_t (logic [4:0]), constant REG_ZERO=5'd0.
  - typedef wb_req_t {rd, data}, parameterised on DWIDTH via package parameter default 32.
- Sub-module rr_arbiter (NREQ, req vector in, one-hot grant out, internal pointer, clk/rst).
  - Reusable for memory-port sharing later.
- Scoreboard remains inline.

Test Plan:
- Reset: hold rst=0, then release -> regwren_o=0, pending_o=0, stall_o=0; req 0 and 1 valid in the first cycle -> req_ready_o=01.
- Round-robin: req 0 and 1 both valid continuously with rd=5/data=0xAAAA and rd=6/data=0xBBBB -> grants alternate 01,10,01. regwren_o rises one cycle after the first grant with rd_o=5, datawb_o=0xAAAA.
- x0 drop: req 0 valid, rd=0, data=0xDEAD -> req_ready_o[0]=1, next cycle regwren_o=0, pending_o unchanged.
- RAW stall: issue_i with rd=7, next cycle rs1_i=7 -> stall_o=1. A grant with rd=7 clears pending[7] one edge after regwren_o=1, then stall_o=0. With WBARB_FWD_EN, stall_o=0 and fwd1_valid_o=1 during the regwren_o cycle.
- Simultaneous set/clear: regwren_o=1 with rd_o=9 while issue_i with rd=9 -> pending_o[9]=1 after the edge.
- Mid-reset: assert rst=0 while regwren_o=1 and pending_o=0x00000480 -> regwren_o=0 and pending_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types: address width, x0 constant, writeback bundle.
// Imported by the writeback arbiter and its round-robin sub-arbiter.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  // Default writeback data width for the bundle type.
  localparam int WB_DWIDTH = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    reg_addr_t              rd;
    logic [WB_DWIDTH-1:0]   data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_bit(
    input reg_addr_t a
  );
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, search starts after last winner.
// Ports: clk, rst (async low), req[N], grant[N] one-hot, grant_idx, any.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  // Reset to N-1 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= IW'(N - 1);
    else if (any)
      ptr <= grant_idx;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register_file write port among NREQ writeback sources and
// tracks in-flight writes for RAW/WAW stalls. Option: WBARB_FWD_EN.
// Ports: req_* handshake, rd_o/datawb_o/regwren_o, issue/rs hazard
// inputs, stall_o, pending_o; fwd*_o only when WBARB_FWD_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NREQ   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*5-1:0]      req_rd_i,
  input  logic [NREQ*DWIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic [4:0]             rd_o,
  output logic [DWIDTH-1:0]      datawb_o,
  output logic                   regwren_o,
  input  logic                   issue_i,
  input  logic [4:0]             issue_rd_i,
  input  logic [4:0]             rs1_i,
  input  logic [4:0]             rs2_i,
  output logic                   stall_o,
`ifdef WBARB_FWD_EN
  output logic                   fwd1_valid_o,
  output logic [DWIDTH-1:0]      fwd1_data_o,
  output logic                   fwd2_valid_o,
  output logic [DWIDTH-1:0]      fwd2_data_o,
`endif
  output logic [31:0]            pending_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]       gidx;
  logic                gany;
  reg_addr_t           sel_rd;
  logic [DWIDTH-1:0]   sel_data;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid_i),
    .grant     (req_ready_o),
    .grant_idx (gidx),
    .any       (gany)
  );

  always_comb begin
    sel_rd   = req_rd_i[int'(gidx)*REG_AW +: REG_AW];
    sel_data = req_data_i[int'(gidx)*DWIDTH +: DWIDTH];
  end

  // x0 writes are accepted but never enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_o      <= REG_ZERO;
      datawb_o  <= '0;
      regwren_o <= 1'b0;
    end else if (gany) begin
      rd_o      <= sel_rd;
      datawb_o  <= sel_data;
      regwren_o <= (sel_rd != REG_ZERO);
    end else begin
      regwren_o <= 1'b0;
    end
  end

  // Clear first, then set, so a same-edge issue keeps the bit.
  always_comb begin
    pending_nxt = pending;
    if (regwren_o)
      pending_nxt = pending_nxt & ~reg_bit(rd_o);
    if (issue_i && issue_rd_i != REG_ZERO)
      pending_nxt = pending_nxt | reg_bit(issue_rd_i);
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  assign pending_o = pending;

`ifdef WBARB_FWD_EN
  always_comb begin
    fwd1_valid_o = regwren_o && (rd_o == rs1_i);
    fwd2_valid_o = regwren_o && (rd_o == rs2_i);
    fwd1_data_o  = datawb_o;
    fwd2_data_o  = datawb_o;
    stall_o = (pending[rs1_i] & ~fwd1_valid_o)
            | (pending[rs2_i] & ~fwd2_valid_o)
            | (issue_i & pending[issue_rd_i]);
  end
`else
  always_comb begin
    stall_o = pending[rs1_i]
            | pending[rs2_i]
            | (issue_i & pending[issue_rd_i]);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, writeback
// register, scoreboard and hazard output.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid_i;
  logic [NR*5-1:0]  req_rd_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]  req_ready_o;
  logic [4:0]     rd_o;
  logic [DW-1:0]  datawb_o;
  logic           regwren_o;
  logic           issue_i;
  logic [4:0]     issue_rd_i;
  logic [4:0]     rs1_i;
  logic [4:0]     rs2_i;
  logic           stall_o;
  logic [31:0]    pending_o;
`ifdef WBARB_FWD_EN
  logic           fwd1_valid_o;
  logic [DW-1:0]  fwd1_data_o;
  logic           fwd2_valid_o;
  logic [DW-1:0]  fwd2_data_o;
`endif

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(
    .DWIDTH(DW),
    .NREQ(NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_rd_i    (req_rd_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .rd_o        (rd_o),
    .datawb_o    (datawb_o),
    .regwren_o   (regwren_o),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .stall_o     (stall_o),
`ifdef WBARB_FWD_EN
    .fwd1_valid_o(fwd1_valid_o),
    .fwd1_data_o (fwd1_data_o),
    .fwd2_valid_o(fwd2_valid_o),
    .fwd2_data_o (fwd2_data_o),
`endif
    .pending_o   (pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic [4:0] rd,
                         input logic [31:0] d);
    req_rd_i[n*5 +: 5]     = rd;
    req_data_i[n*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b0;
    req_valid_i = '0;
    req_rd_i = '0;
    req_data_i = '0;
    issue_i = 1'b0;
    issue_rd_i = '0;
    rs1_i = '0;
    rs2_i = '0;
    #12;
    chk("rst_regwren", 32'(regwren_o), 32'h0);
    chk("rst_pending", pending_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_rd", 32'(rd_o), 32'h0);
    chk("rst_data", datawb_o, 32'h0);
    rst = 1'b1;
    step();

    // Round-robin with both requesters valid.
    set_req(0, 5'd5, 32'h0000AAAA);
    set_req(1, 5'd6, 32'h0000BBBB);
    req_valid_i = 2'b11;
    #1;
    chk("rr_g0", 32'(req_ready_o), 32'h1);
    step();
    chk("rr_g1", 32'(req_ready_o), 32'h2);
    chk("rr_wren1", 32'(regwren_o), 32'h1);
    chk("rr_rd1", 32'(rd_o), 32'h5);
    chk("rr_data1", datawb_o, 32'h0000AAAA);
    step();
    chk("rr_g2", 32'(req_ready_o), 32'h1);
    chk("rr_rd2", 32'(rd_o), 32'h6);
    chk("rr_data2", datawb_o, 32'h0000BBBB);
    step();
    req_valid_i = 2'b00;
    #1;
    chk("rr_rd3", 32'(rd_o), 32'h5);
    chk("idle_ready", 32'(req_ready_o), 32'h0);
    step();
    chk("idle_wren", 32'(regwren_o), 32'h0);
    chk("idle_rd_hold", 32'(rd_o), 32'h5);
    chk("idle_data_hold", datawb_o, 32'h0000AAAA);

    // Only requester 1 valid, then withdrawn before the edge.
    req_valid_i = 2'b10;
    #1;
    chk("only1_ready", 32'(req_ready_o), 32'h2);
    req_valid_i = 2'b00;
    #1;
    chk("drop_ready", 32'(req_ready_o), 32'h0);
    step();
    chk("drop_wren", 32'(regwren_o), 32'h0);
    chk("drop_rd", 32'(rd_o), 32'h5);

    // x0 write accepted, then dropped.
    set_req(0, 5'd0, 32'h0000DEAD);
    req_valid_i = 2'b01;
    #1;
    chk("x0_ready", 32'(req_ready_o), 32'h1);
    step();
    req_valid_i = 2'b00;
    chk("x0_wren", 32'(regwren_o), 32'h0);
    chk("x0_pending", pending_o, 32'h0);

    // RAW / WAW hazard on x7.
    issue_i = 1'b1;
    issue_rd_i = 5'd7;
    #1;
    chk("iss_stall", 32'(stall_o), 32'h0);
    step();
    issue_i = 1'b0;
    chk("iss_pending", pending_o, 32'h00000080);
    rs1_i = 5'd7;
    #1;
    chk("raw_rs1", 32'(stall_o), 32'h1);
    rs1_i = 5'd0;
    rs2_i = 5'd7;
    #1;
    chk("raw_rs2", 32'(stall_o), 32'h1);
    rs2_i = 5'd0;
    issue_i = 1'b1;
    #1;
    chk("waw_stall", 32'(stall_o), 32'h1);
    issue_i = 1'b0;
    #1;
    chk("no_stall", 32'(stall_o), 32'h0);
    set_req(0, 5'd7, 32'h00001234);
    req_valid_i = 2'b01;
    rs1_i = 5'd7;
    #1;
    chk("w7_ready", 32'(req_ready_o), 32'h1);
    step();
    req_valid_i = 2'b00;
    chk("w7_wren", 32'(regwren_o), 32'h1);
    chk("w7_rd", 32'(rd_o), 32'h7);
    chk("w7_pend", pending_o, 32'h00000080);
`ifdef WBARB_FWD_EN
    chk("w7_stall_fwd", 32'(stall_o), 32'h0);
    chk("w7_fwd1v", 32'(fwd1_valid_o), 32'h1);
    chk("w7_fwd1d", fwd1_data_o, 32'h00001234);
`else
    chk("w7_stall", 32'(stall_o), 32'h1);
`endif
    step();
    chk("w7_clr_pend", pending_o, 32'h0);
    chk("w7_clr_stall", 32'(stall_o), 32'h0);
    rs1_i = 5'd0;

    // Same-edge set and clear of x9: set wins.
    set_req(0, 5'd9, 32'h00000099);
    req_valid_i = 2'b01;
    step();
    req_valid_i = 2'b00;
    chk("w9_wren", 32'(regwren_o), 32'h1);
    issue_i = 1'b1;
    issue_rd_i = 5'd9;
    step();
    issue_i = 1'b0;
    chk("setclr_pend", pending_o, 32'h00000200);

    // Build pending=0x480 with a write in flight, then reset mid-cycle.
    issue_i = 1'b1;
    issue_rd_i = 5'd7;
    set_req(0, 5'd9, 32'h00005555);
    req_valid_i = 2'b01;
    step();
    chk("mr_pend1", pending_o, 32'h00000280);
    issue_rd_i = 5'd10;
    set_req(0, 5'd3, 32'h00003333);
    step();
    issue_i = 1'b0;
    chk("mr_pend2", pending_o, 32'h00000480);
    chk("mr_wren", 32'(regwren_o), 32'h1);
    chk("mr_rd", 32'(rd_o), 32'h3);
    req_valid_i = 2'b11;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_wren0", 32'(regwren_o), 32'h0);
    chk("mr_pend0", pending_o, 32'h0);
    chk("mr_rd0", 32'(rd_o), 32'h0);
    chk("mr_ready", 32'(req_ready_o), 32'h1);
    #10;
    rst = 1'b1;
    req_valid_i = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
